// File: rtl/alu_op_decoder_pkg.sv
// Shared types for the ALU decode stage: ALU op codes, major opcodes and the decoded entry.
package alu_pkg;

    localparam int N     = 32;
    localparam int RA_W  = 5;
    localparam int OPC_W = 6;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_XOR = 5'd4,
        ALU_SLL = 5'd5,
        ALU_SRL = 5'd6,
        ALU_SLA = 5'd7,
        ALU_SRA = 5'd8,
        ALU_LUI = 5'd9,
        ALU_LLI = 5'd10
    } alu_op_e;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h01;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 6'h02;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'h03;
    localparam logic [OPC_W-1:0] OPC_XORI  = 6'h04;
    localparam logic [OPC_W-1:0] OPC_LUI   = 6'h05;
    localparam logic [OPC_W-1:0] OPC_LLI   = 6'h06;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h07;

    localparam logic [4:0] FUNCT_MAX = 5'd8;

    typedef struct packed {
        alu_op_e         alu_op;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [N-1:0]    imm;
        logic            use_imm;
        logic            reg_write;
        logic            is_branch;
        logic            illegal;
    } decoded_t;

    function automatic logic [N-1:0] sign_ext16(input logic [15:0] v);
        return {{(N-16){v[15]}}, v};
    endfunction

    function automatic logic [N-1:0] zero_ext16(input logic [15:0] v);
        return {{(N-16){1'b0}}, v};
    endfunction

endpackage

// File: rtl/alu_op_decoder_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface alu_op_decoder_if;
    import alu_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      alu_op;
    logic [RA_W-1:0] rd_addr;
    logic [RA_W-1:0] rs_addr;
    logic [RA_W-1:0] rt_addr;
    logic [N-1:0]    imm;
    logic            use_imm;
    logic            reg_write;
    logic            is_branch;
    logic            illegal;

    modport slave (
        input  flush, in_valid, instr, out_ready,
        output in_ready, out_valid, alu_op, rd_addr, rs_addr, rt_addr,
               imm, use_imm, reg_write, is_branch, illegal
    );

    modport master (
        output flush, in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_op, rd_addr, rs_addr, rt_addr,
               imm, use_imm, reg_write, is_branch, illegal
    );

endinterface

// File: rtl/alu_op_decoder_instr_field_decode.sv
// Pure combinational instruction-word to decoded-entry translation.
module instr_field_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [OPC_W-1:0] opc_s;
    logic [4:0]       funct_s;
    logic [15:0]      imm16_s;

    assign opc_s   = instr[31:26];
    assign funct_s = instr[4:0];
    assign imm16_s = instr[15:0];

    // field extraction and op/flag selection; illegal words leave every field at zero
    always_comb begin
        dec = '0;
        case (opc_s)
            OPC_RTYPE: begin
                if (funct_s <= FUNCT_MAX) begin
                    dec.alu_op    = alu_op_e'(funct_s);
                    dec.rd        = instr[25:21];
                    dec.rs        = instr[20:16];
                    dec.rt        = instr[15:11];
                    dec.reg_write = 1'b1;
                end else begin
                    dec.illegal   = 1'b1;
                end
            end
            OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI, OPC_LLI: begin
                dec.rd        = instr[25:21];
                dec.rs        = instr[20:16];
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
                if (opc_s == OPC_ADDI) begin
                    dec.imm = sign_ext16(imm16_s);
                end else begin
                    dec.imm = zero_ext16(imm16_s);
                end
                case (opc_s)
                    OPC_ADDI: dec.alu_op = ALU_ADD;
                    OPC_ANDI: dec.alu_op = ALU_AND;
                    OPC_ORI:  dec.alu_op = ALU_OR;
                    OPC_XORI: dec.alu_op = ALU_XOR;
                    OPC_LUI:  dec.alu_op = ALU_LUI;
                    OPC_LLI:  dec.alu_op = ALU_LLI;
                    default:  dec.alu_op = ALU_ADD;
                endcase
            end
            OPC_BEQ: begin
                // branch compares rs and rt through SUB; offset rides along in imm
                dec.alu_op    = ALU_SUB;
                dec.rs        = instr[20:16];
                dec.rt        = instr[15:11];
                dec.imm       = sign_ext16(imm16_s);
                dec.is_branch = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_decoder.sv
// ID/EX decode stage: decodes fetched instructions into a main register backed by a one-entry skid.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_op_decoder_if.slave   bus
);

    decoded_t dec_s;
    decoded_t main_r;
    decoded_t skid_r;
    logic     main_valid_r;
    logic     skid_valid_r;
    logic     accept_s;
    logic     drain_s;

    instr_field_decode u_decode (
        .instr (bus.instr),
        .dec   (dec_s)
    );

    // in_ready depends only on the skid flag, so out_ready never reaches it combinationally
    assign bus.in_ready = ~skid_valid_r;
    assign accept_s     = bus.in_valid & ~skid_valid_r;
    assign drain_s      = main_valid_r & bus.out_ready;

    // main/skid pipeline entries; reset beats flush, flush beats accept and drain
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (bus.flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!main_valid_r || drain_s) begin
            if (skid_valid_r) begin
                main_r       <= skid_r;
                main_valid_r <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                main_r       <= dec_s;
                main_valid_r <= 1'b1;
            end else begin
                main_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

    assign bus.out_valid = main_valid_r;
    assign bus.alu_op    = main_r.alu_op;
    assign bus.rd_addr   = main_r.rd;
    assign bus.rs_addr   = main_r.rs;
    assign bus.rt_addr   = main_r.rt;
    assign bus.imm       = main_r.imm;
    assign bus.use_imm   = main_r.use_imm;
    assign bus.reg_write = main_r.reg_write;
    assign bus.is_branch = main_r.is_branch;
    assign bus.illegal   = main_r.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: directed cases then randomized traffic, flush and reset.
module tb_alu_op_decoder;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        is_branch;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    alu_op_decoder_if bus ();

    alu_op_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    bit   pend_valid = 1'b0;
    bit   pend_clear = 1'b0;
    bit   pend_rst   = 1'b0;
    exp_t pend_item;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endfunction

    // Reference decode written straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   opc;
        int   funct;
        int   itab[6];
        itab  = '{0, 2, 3, 4, 9, 10};
        e     = '0;
        opc   = int'(w[31:26]);
        funct = int'(w[4:0]);
        if (opc == 0) begin
            if (funct <= 8) begin
                e.op = 5'(funct); e.rd = w[25:21]; e.rs = w[20:16]; e.rt = w[15:11];
                e.reg_write = 1'b1;
            end else e.illegal = 1'b1;
        end else if (opc >= 1 && opc <= 6) begin
            e.op = 5'(itab[opc-1]); e.rd = w[25:21]; e.rs = w[20:16];
            e.imm = {16'h0000, w[15:0]};
            if (opc == 1 && w[15]) e.imm = e.imm + 32'hFFFF_0000;
            e.use_imm = 1'b1; e.reg_write = 1'b1;
        end else if (opc == 7) begin
            e.op = 5'd1; e.rs = w[20:16]; e.rt = w[15:11];
            e.imm = {16'h0000, w[15:0]};
            if (w[15]) e.imm = e.imm + 32'hFFFF_0000;
            e.is_branch = 1'b1;
        end else e.illegal = 1'b1;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = '{bus.alu_op, bus.rd_addr, bus.rs_addr, bus.rt_addr, bus.imm,
              bus.use_imm, bus.reg_write, bus.is_branch, bus.illegal};
        return a;
    endfunction

    // Folds in what the last edge did to the expected contents, then drives the next cycle.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                        input logic fl, input logic rs);
        @(posedge clk); #1;
        if (pend_clear) exp_q.delete();
        else if (pend_valid) exp_q.push_back(pend_item);
        if (pend_rst) begin
            chk("reset_state", {bus.out_valid, bus.in_ready, 62'(actual())}, {1'b0, 1'b1, 62'd0});
            mon_en = 1'b1;
        end
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst           = rs;
        pend_valid    = v && bus.in_ready && !fl && !rs;
        pend_item     = model(ins);
        pend_clear    = fl || rs;
        pend_rst      = rs;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) < 8) w[31:26] = 6'($urandom_range(0, 7));
        if (w[31:26] == 6'h00 && $urandom_range(0, 3) != 0) w[4:0] = 5'($urandom_range(0, 8));
        return w;
    endfunction

    exp_t prev_out;
    bit   prev_hold = 1'b0;

    // Monitor: occupancy-driven ready/valid, head-of-queue comparison, hold stability.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            if (prev_hold) chk("hold_stable", 64'(actual()), 64'(prev_out));
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("entry", 64'(actual()), 64'(exp_q[0]));
                if (bus.out_ready && !bus.flush && !rst) void'(exp_q.pop_front());
            end
            prev_hold = bus.out_valid && !bus.out_ready && !bus.flush && !rst;
            prev_out  = actual();
        end
    end

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.instr = 32'h0;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        // XOR rd=3 rs=1 rt=2, then ADDI/ORI with all-ones immediate
        step(1'b1, {6'h00, 5'd3, 5'd1, 5'd2, 6'd0, 5'd4}, 1'b1, 1'b0, 1'b0);
        step(1'b1, {6'h01, 5'd5, 5'd6, 16'hFFFF}, 1'b1, 1'b0, 1'b0);
        step(1'b1, {6'h03, 5'd7, 5'd8, 16'hFFFF}, 1'b1, 1'b0, 1'b0);
        // three back-to-back under backpressure, then release
        step(1'b1, {6'h02, 5'd1, 5'd2, 16'h1234}, 1'b0, 1'b0, 1'b0);
        step(1'b1, {6'h04, 5'd3, 5'd4, 16'h8765}, 1'b0, 1'b0, 1'b0);
        step(1'b1, {6'h05, 5'd5, 5'd6, 16'hABCD}, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        // flush with both entries held and a new word offered
        step(1'b1, {6'h06, 5'd9, 5'd10, 16'h00FF}, 1'b0, 1'b0, 1'b0);
        step(1'b1, {6'h00, 5'd11, 5'd12, 5'd13, 6'd0, 5'd8}, 1'b0, 1'b0, 1'b0);
        step(1'b1, {6'h01, 5'd1, 5'd1, 16'h0001}, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        // illegal opcode and illegal funct keep flowing
        step(1'b1, {6'h3F, 5'd31, 5'd31, 16'hFFFF}, 1'b1, 1'b0, 1'b0);
        step(1'b1, {6'h00, 5'd4, 5'd5, 5'd6, 6'd0, 5'd12}, 1'b1, 1'b0, 1'b0);
        step(1'b1, {6'h00, 5'd1, 5'd2, 5'd3, 6'd0, 5'd0}, 1'b1, 1'b0, 1'b0);
        // reset with entries held, then BEQ with a nonzero rd field
        step(1'b1, {6'h01, 5'd2, 5'd3, 16'h7FFF}, 1'b0, 1'b0, 1'b0);
        step(1'b1, {6'h02, 5'd4, 5'd5, 16'h8000}, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, {6'h07, 5'd9, 5'd4, 16'h8001}, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        if (pend_clear) exp_q.delete();
        else if (pend_valid) exp_q.push_back(pend_item);
        chk("drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
